// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add sequencer for MUL/MULH/MULHU, stalling the CPU while it computes
module mul_seq_ctrl #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            mulh,
   input  logic            u,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic            flush,
   output logic            stall,
   output logic            valid,
   output logic [XLEN-1:0] result
);
   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] prod, mcand, prod_add, prod_fix;
   logic [XLEN-1:0]   mplier, abs1, abs2;
   logic              neg, low, sgn_op;

   // MULH works on magnitudes and re-applies the sign in FIX; u takes priority over mulh
   assign sgn_op   = mulh & ~u;
   assign abs1     = rs1_val[XLEN-1] ? -rs1_val : rs1_val;
   assign abs2     = rs2_val[XLEN-1] ? -rs2_val : rs2_val;
   assign prod_fix = neg ? -prod : prod;
   assign valid    = state == DONE;
   assign stall    = rst_n & ~flush & ((state == IDLE & start) | state == CALC | state == FIX);

   always_comb begin
      prod_add = prod;
      for (int k = 0; k < BITS_PER_CYCLE; k++)
         prod_add = prod_add + (mplier[k] ? mcand << k : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         low    <= 1'b0;
         result <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               low    <= ~mulh & ~u;
               neg    <= sgn_op & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
               mcand  <= {{XLEN{1'b0}}, sgn_op ? abs1 : rs1_val};
               mplier <= sgn_op ? abs2 : rs2_val;
               prod   <= '0;
               cnt    <= '0;
               state  <= CALC;
            end
            CALC: begin
               prod   <= prod_add;
               mcand  <= mcand << BITS_PER_CYCLE;
               mplier <= mplier >> BITS_PER_CYCLE;
               cnt    <= cnt + 1'b1;
               state  <= (cnt == CW'(N - 1)) ? FIX : CALC;
            end
            FIX: begin
               prod   <= prod_fix;
               result <= low ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: transaction-level reference model with per-cycle compare, directed and random ops
module tb_mul_seq_ctrl;
   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, mulh = 1'b0, u = 1'b0, flush = 1'b0;
   logic [31:0] rs1_val = '0, rs2_val = '0;
   logic        stall, valid;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   mul_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mulh(mulh), .u(u),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
      .stall(stall), .valid(valid), .result(result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic mh, input logic uu, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      if (mh && !uu) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else p = {32'd0, a} * {32'd0, b};
      return (!mh && !uu) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: phase = cycles since the start was accepted (0 = idle); result lands at N+2
   int          mphase = 0;
   logic [31:0] mpend = '0, mres = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mphase <= 0;
         mres   <= '0;
      end else if (flush) mphase <= 0;
      else if (mphase == 0) begin
         if (start) begin
            mphase <= 1;
            mpend  <= ref_mul(mulh, u, rs1_val, rs2_val);
         end
      end else if (mphase == N + 2) mphase <= 0;
      else begin
         mphase <= mphase + 1;
         if (mphase == N + 1) mres <= mpend;
      end
   end

   always @(negedge clk) begin
      check("stall", {31'd0, stall},
            {31'd0, rst_n && !flush && ((mphase == 0 && start) || (mphase >= 1 && mphase <= N + 1))});
      check("valid", {31'd0, valid}, {31'd0, mphase == N + 2});
      check("result", result, mres);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic mh, input logic uu, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int st, output logic [31:0] r);
      mulh = mh; u = uu; rs1_val = a; rs2_val = b; start = 1'b1;
      lat = 0; st = 0;
      forever begin
         @(negedge clk);
         if (stall) st++;
         if (valid) break;
         lat++;
         if (lat > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no valid after %0d cycles", lat);
            break;
         end
      end
      r = result;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat, lat2, st, nv, bound;
      logic [31:0] r;
      logic aborted;
      check("pin_mul", ref_mul(0, 0, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFA);
      check("pin_mulh", ref_mul(1, 0, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFF);
      check("pin_mulhu", ref_mul(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      check("pin_mulh_min", ref_mul(1, 0, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      run_op(0, 0, 32'd3, 32'd5, lat, st, r);
      check("mul3x5_lat", lat, 34);
      check("mul3x5_stall", st, 34);
      check("mul3x5_res", r, 32'h0000_000F);
      step(); start = 0; step();
      run_op(1, 0, 32'hFFFF_FFFE, 32'd3, lat, st, r);
      check("mulh_neg", r, 32'hFFFF_FFFF);
      step(); start = 0; step();
      run_op(0, 0, 32'hFFFF_FFFE, 32'd3, lat, st, r);
      check("mul_neg", r, 32'hFFFF_FFFA);
      step(); start = 0; step();
      run_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, st, r);
      check("mulhu", r, 32'hFFFF_FFFE);
      step(); start = 0; step();
      run_op(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, st, r);
      check("mulh_u_wins", r, 32'hFFFF_FFFE);
      step(); start = 0; step();
      run_op(1, 0, 32'h8000_0000, 32'h8000_0000, lat, st, r);
      check("mulh_min", r, 32'h4000_0000);
      step(); start = 0; step();
      run_op(0, 0, 32'd7, 32'd6, lat, st, r);
      check("b2b_first_lat", lat, 34);
      check("b2b_first_res", r, 32'h0000_002A);
      step();
      run_op(1, 0, 32'h8000_0000, 32'd1, lat2, st, r);
      check("b2b_second_at", lat + 1 + lat2, 69);
      check("b2b_second_res", r, 32'hFFFF_FFFF);
      step(); start = 0; step();
      // async reset mid-CALC with start still asserted
      mulh = 0; u = 0; rs1_val = 32'd9; rs2_val = 32'd9; start = 1;
      repeat (11) step();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_result", result, 32'd0);
      step();
      rst_n = 1'b1;
      run_op(0, 0, 32'd2, 32'd2, lat, st, r);
      check("post_rst_lat", lat, 34);
      check("post_rst_res", r, 32'd4);
      step(); start = 0; step();
      // flush at CALC cycle 5
      rs1_val = 32'd5; rs2_val = 32'd5; start = 1;
      repeat (6) step();
      flush = 1;
      @(negedge clk);
      check("flush_stall", {31'd0, stall}, 32'd0);
      step(); flush = 0; start = 0;
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) nv++;
      end
      check("flush_no_valid", nv, 0);
      step();
      run_op(0, 0, 32'd3, 32'd3, lat, st, r);
      check("post_flush_lat", lat, 34);
      check("post_flush_res", r, 32'd9);
      step(); start = 0; step();
      // random ops, operands scrambled while busy, occasional flush
      for (int i = 0; i < 80; i++) begin
         repeat ($urandom_range(0, 2)) begin
            start = 0;
            step();
         end
         mulh = 1'($urandom); u = 1'($urandom); rs1_val = pick(); rs2_val = pick(); start = 1;
         aborted = 0;
         bound = 0;
         forever begin
            @(negedge clk);
            if (valid) break;
            step();
            rs1_val = $urandom; rs2_val = $urandom;
            if (mphase != N + 2 && $urandom_range(0, 49) == 0) begin
               flush = 1;
               step();
               flush = 0; start = 0;
               aborted = 1;
               break;
            end
            if (++bound > 200) begin
               n_cmp++; n_bad++;
               $display("FAIL rand_timeout: op %0d", i);
               break;
            end
         end
         if (!aborted) step();
      end
      start = 0;
      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
